// File: rtl/periph_apb_demux_pkg.sv
// Shared types and constants for the APB demux: FSM state encoding,
// error response data, counter widths and a saturating increment helper.
package periph_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR
  } apb_state_e;

  localparam int ERR_DATA  = 0;
  localparam int TMO_CNT_W = 16;
  localparam int ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/periph_apb_demux_if.sv
// APB bus bundle for the demux: upstream requester side plus the
// shared/fanned-out downstream side. slave = demux view, master = driver view.
interface periph_apb_if #(
  parameter int NB_SLV         = 11,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [APB_DATA_WIDTH-1:0] pwdata_i;
  logic                      pwrite_i;
  logic                      psel_i;
  logic                      penable_i;
  logic [APB_DATA_WIDTH-1:0] prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  logic [APB_ADDR_WIDTH-1:0] m_paddr_o;
  logic [APB_DATA_WIDTH-1:0] m_pwdata_o;
  logic                      m_pwrite_o;
  logic                      m_penable_o;
  logic [NB_SLV-1:0]         m_psel_o;
  logic [NB_SLV-1:0][APB_DATA_WIDTH-1:0] m_prdata_i;
  logic [NB_SLV-1:0]         m_pready_i;
  logic [NB_SLV-1:0]         m_pslverr_i;

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i,
    input  psel_i, penable_i,
    output prdata_o, pready_o, pslverr_o,
    output m_paddr_o, m_pwdata_o, m_pwrite_o,
    output m_penable_o, m_psel_o,
    input  m_prdata_i, m_pready_i, m_pslverr_i
  );

  modport master (
    output paddr_i, pwdata_i, pwrite_i,
    output psel_i, penable_i,
    input  prdata_o, pready_o, pslverr_o,
    input  m_paddr_o, m_pwdata_o, m_pwrite_o,
    input  m_penable_o, m_psel_o,
    output m_prdata_i, m_pready_i, m_pslverr_i
  );
endinterface

// File: rtl/periph_apb_demux_addr_dec.sv
// Priority address decoder: inputs i_paddr and per-target inclusive windows
// i_start/i_end; outputs o_hit and o_idx (lowest matching index wins).
module periph_apb_addr_dec #(
  parameter int NB_SLV = 11,
  parameter int AW     = 32,
  parameter int IDX_W  = 4
) (
  input  logic [AW-1:0]             i_paddr,
  input  logic [NB_SLV-1:0][AW-1:0] i_start,
  input  logic [NB_SLV-1:0][AW-1:0] i_end,
  output logic                      o_hit,
  output logic [IDX_W-1:0]          o_idx
);

  // Scan high to low so the lowest index overwrites last.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NB_SLV - 1; i >= 0; i--) begin
      if (i_paddr >= i_start[i] && i_paddr <= i_end[i]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/periph_apb_demux.sv
// APB 1-to-NB_SLV demux with registered FSM. Ports: clk_i, rst_i, bus
// (periph_apb_if.slave), start/end_addr_i windows, err_cnt_o error count.
// Optional ACCESS timeout enabled by macro PERIPH_APB_TIMEOUT_EN.
module periph_apb_demux
  import periph_apb_pkg::*;
#(
  parameter int NB_SLV         = 11,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  periph_apb_if.slave                           bus,
  input  logic [NB_SLV-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLV-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic [ERR_CNT_W-1:0]                  err_cnt_o
);

  localparam int IDX_W = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;
  localparam logic [APB_DATA_WIDTH-1:0] ERR_D =
    APB_DATA_WIDTH'(ERR_DATA);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
      NB_SLV < 1 || NB_SLV > 32) begin : g_bad_cfg
    $error("periph_apb_demux: parameter out of range");
  end

  apb_state_e                r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [APB_ADDR_WIDTH-1:0] r_m_paddr;
  logic [APB_DATA_WIDTH-1:0] r_m_pwdata;
  logic                      r_m_pwrite;
  logic                      r_m_penable;
  logic [NB_SLV-1:0]         r_m_psel;
  logic [APB_DATA_WIDTH-1:0] r_prdata;
  logic                      r_pready;
  logic                      r_pslverr;
  logic [ERR_CNT_W-1:0]      r_err_cnt;
`ifdef PERIPH_APB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST =
    TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_CNT_W-1:0]      r_tmo;
`endif

  logic                      w_hit;
  logic [IDX_W-1:0]          w_idx;

  periph_apb_addr_dec #(
    .NB_SLV (NB_SLV),
    .AW     (APB_ADDR_WIDTH),
    .IDX_W  (IDX_W)
  ) u_dec (
    .i_paddr (bus.paddr_i),
    .i_start (start_addr_i),
    .i_end   (end_addr_i),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_m_paddr   <= '0;
      r_m_pwdata  <= '0;
      r_m_pwrite  <= 1'b0;
      r_m_penable <= 1'b0;
      r_m_psel    <= '0;
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_err_cnt   <= '0;
`ifdef PERIPH_APB_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
`ifdef PERIPH_APB_TIMEOUT_EN
          r_tmo <= '0;
`endif
          if (bus.psel_i && !bus.penable_i) begin
            r_m_paddr  <= bus.paddr_i;
            r_m_pwdata <= bus.pwdata_i;
            r_m_pwrite <= bus.pwrite_i;
            r_idx      <= w_idx;
            if (w_hit) begin
              r_state  <= SETUP;
              r_m_psel <= NB_SLV'(1) << w_idx;
            end else begin
              r_state   <= ERR;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_prdata  <= ERR_D;
            end
          end
        end
        SETUP: begin
          r_m_penable <= 1'b1;
          r_state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.m_pready_i[r_idx]) begin
            r_m_psel    <= '0;
            r_m_penable <= 1'b0;
            r_prdata    <= bus.m_prdata_i[r_idx];
            r_pslverr   <= bus.m_pslverr_i[r_idx];
            r_pready    <= 1'b1;
            r_state     <= RESP;
          end
`ifdef PERIPH_APB_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            // Abandon the stalled target and answer with an error.
            r_m_psel    <= '0;
            r_m_penable <= 1'b0;
            r_prdata    <= ERR_D;
            r_pslverr   <= 1'b1;
            r_pready    <= 1'b1;
            r_state     <= ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
          r_state   <= IDLE;
        end
        ERR: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
          r_err_cnt <= sat_inc(r_err_cnt);
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_paddr_o   = r_m_paddr;
  assign bus.m_pwdata_o  = r_m_pwdata;
  assign bus.m_pwrite_o  = r_m_pwrite;
  assign bus.m_penable_o = r_m_penable;
  assign bus.m_psel_o    = r_m_psel;
  assign bus.prdata_o    = r_prdata;
  assign bus.pready_o    = r_pready;
  assign bus.pslverr_o   = r_pslverr;
  assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_periph_apb_demux.sv
// Scoreboard bench for periph_apb_demux: decode, latency, error paths,
// reset during ACCESS and error counter saturation.
module tb_periph_apb_demux;

  localparam int NB  = 11;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef PERIPH_APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NB-1:0][AW-1:0] st;
  logic [NB-1:0][AW-1:0] en;
  logic [7:0]            err_cnt;

  periph_apb_if #(
    .NB_SLV(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)
  ) bus ();

  periph_apb_demux #(
    .NB_SLV(NB), .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus.slave),
    .start_addr_i (st),
    .end_addr_i   (en),
    .err_cnt_o    (err_cnt)
  );

  typedef struct {
    logic [NB-1:0] psel;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            wait_n[NB];
  logic [DW-1:0] tdata[NB];
  logic [NB-1:0] terr;
  int            exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [AW-1:0] a);
    for (int i = 0; i < NB; i++)
      if (a >= st[i] && a <= en[i]) return i;
    return -1;
  endfunction

  task automatic xfer(input logic [AW-1:0] a, input logic w,
                      input logic [DW-1:0] wd, input string tag);
    exp_t          e;
    int            idx;
    int            lat;
    int            wc;
    logic [NB-1:0] seen;
    bit            done;
    idx = dec(a);
    if (idx < 0) begin
      e.psel = '0; e.rdata = '0; e.err = 1'b1; e.lat = 1;
      if (exp_err < 255) exp_err++;
    end else if (TMO_EN && wait_n[idx] >= TMO) begin
      e.psel = NB'(1) << idx; e.rdata = '0; e.err = 1'b1;
      e.lat = 2 + TMO;
      if (exp_err < 255) exp_err++;
    end else begin
      e.psel = NB'(1) << idx; e.rdata = tdata[idx];
      e.err = terr[idx]; e.lat = 3 + wait_n[idx];
    end
    sb.push_back(e);
    @(negedge clk);
    bus.paddr_i = a; bus.pwdata_i = wd; bus.pwrite_i = w;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0;
    bus.m_pready_i = '0;
    lat = 0; wc = 0; seen = '0; done = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      bus.penable_i = 1'b1;
      seen |= bus.m_psel_o;
      if (bus.m_psel_o != '0) begin
        chk({tag, ".maddr"}, bus.m_paddr_o, a);
        chk({tag, ".mwr"}, 32'(bus.m_pwrite_o), 32'(w));
        chk({tag, ".mwd"}, bus.m_pwdata_o, wd);
      end
      if (bus.m_penable_o) begin
        bus.m_pready_i = (wc >= (idx < 0 ? 0 : wait_n[idx])) ?
                         '1 : '0;
        wc++;
      end
      done = bus.pready_o;
    end
    e = sb.pop_front();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
    chk({tag, ".psel"}, 32'(seen), 32'(e.psel));
    chk({tag, ".rdata"}, bus.prdata_o, e.rdata);
    chk({tag, ".slverr"}, 32'(bus.pslverr_o), 32'(e.err));
    chk({tag, ".pselrsp"}, 32'(bus.m_psel_o), 32'd0);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    @(negedge clk);
    chk({tag, ".rdyidle"}, 32'(bus.pready_o), 32'd0);
    chk({tag, ".rdidle"}, bus.prdata_o, 32'd0);
    chk({tag, ".errcnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      st[i] = 32'h1A10_0000 + 32'(i - 1) * 32'h1000;
      en[i] = st[i] + 32'h0FFF;
      tdata[i] = 32'h1000_0000 + 32'(i);
      wait_n[i] = 0;
    end
    st[0] = 32'h1A00_0000; en[0] = 32'h1A00_0FFF;
    st[5] = 32'h1A10_1800; en[5] = 32'h1A10_4FFF;
    tdata[1] = 32'hCAFE_F00D;
    terr = '0; terr[7] = 1'b1;
    wait_n[3] = 2;
    for (int i = 0; i < NB; i++) bus.m_prdata_i[i] = tdata[i];
    bus.m_pslverr_i = terr;
    bus.m_pready_i = '0;
    bus.paddr_i = '0; bus.pwdata_i = '0; bus.pwrite_i = 1'b0;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.psel", 32'(bus.m_psel_o), 32'd0);
    chk("rst.rdy", 32'(bus.pready_o), 32'd0);
    chk("rst.rd", bus.prdata_o, 32'd0);
    chk("rst.err", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    xfer(32'h1A10_0004, 1'b0, 32'h0, "rd1");
    xfer(32'h1A10_0FFF, 1'b1, 32'h1234_5678, "wr1end");
    xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, "miss");
    xfer(32'h1A10_1900, 1'b0, 32'h0, "ovl25");
    xfer(32'h1A10_2004, 1'b0, 32'h0, "wait3");
    xfer(32'h1A10_4800, 1'b1, 32'h5555_AAAA, "t5");
    xfer(32'h1A10_6000, 1'b0, 32'h0, "t7err");
    xfer(32'h1A00_0000, 1'b0, 32'h0, "t0");
    xfer(32'h1A10_9FFF, 1'b0, 32'h0, "t10end");
    xfer(32'h1A10_A000, 1'b0, 32'h0, "pastend");
`ifdef PERIPH_APB_TIMEOUT_EN
    wait_n[4] = 1000;
    xfer(32'h1A10_3010, 1'b0, 32'h0, "tmo");
    wait_n[4] = 0;
`endif

    wait_n[4] = 1000;
    bus.m_pready_i = '0;
    @(negedge clk);
    bus.paddr_i = 32'h1A10_3010; bus.pwrite_i = 1'b0;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0;
    @(negedge clk);
    bus.penable_i = 1'b1;
    @(negedge clk);
    chk("rstacc.pre", 32'(bus.m_penable_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstacc.psel", 32'(bus.m_psel_o), 32'd0);
    chk("rstacc.rdy", 32'(bus.pready_o), 32'd0);
    chk("rstacc.err", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    exp_err = 0;
    wait_n[4] = 0;
    xfer(32'h1A10_0004, 1'b0, 32'h0, "postrst");

    repeat (260) xfer(32'h0000_0010, 1'b0, 32'h0, "sat");
    chk("sat.final", 32'(err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_apb_demux.md
PERIPH_APB_DEMUX -- requirements
Module: periph_apb_demux

Interface
REQ-001 SHALL have parameter NB_SLV, default 11: number of downstream APB targets (1..32).
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter APB_DATA_WIDTH, default 32: data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: ACCESS-phase wait limit before abort (1..65535).
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1); one clock, reset synchronous and active-high.
REQ-006 SHALL have upstream inputs paddr_i (ADDR), pwdata_i (DATA), pwrite_i (1), psel_i (1), penable_i (1): APB requester.
REQ-007 SHALL have upstream outputs prdata_o (DATA), pready_o (1), pslverr_o (1).
REQ-008 SHALL have downstream outputs m_paddr_o (ADDR), m_pwdata_o (DATA), m_pwrite_o (1), m_penable_o (1), shared by all targets, and m_psel_o (NB_SLV, one-hot).
REQ-009 SHALL have downstream inputs m_prdata_i (NB_SLV x DATA), m_pready_i (NB_SLV), m_pslverr_i (NB_SLV).
REQ-010 SHALL have inputs start_addr_i and end_addr_i (NB_SLV x ADDR each): inclusive address window per target.
REQ-011 SHALL have output err_cnt_o (8): saturating count of decode-miss and timeout errors.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, ERR.
REQ-013 IDLE: on psel_i=1 and penable_i=0, SHALL register paddr/pwdata/pwrite and decoded index, then go to SETUP on a hit or to ERR on a miss.
REQ-014 Decode: target i hits when start_addr_i[i] <= paddr_i <= end_addr_i[i]; with several hits, the lowest index SHALL win.
REQ-015 SETUP: SHALL drive m_psel_o[idx]=1 and m_penable_o=0 for exactly one cycle, then go to ACCESS.
REQ-016 ACCESS: SHALL hold m_psel_o[idx]=1 and m_penable_o=1; on m_pready_i[idx]=1, SHALL register m_prdata_i[idx] and m_pslverr_i[idx] and go to RESP.
REQ-017 RESP: SHALL drive pready_o=1 with the registered prdata_o and pslverr_o for one cycle, then go to IDLE; all m_psel_o SHALL be 0.
REQ-018 ERR: SHALL drive pready_o=1, pslverr_o=1 and prdata_o=0 for one cycle, increment err_cnt_o, then go to IDLE.
REQ-019 Latency: a zero-wait target SHALL give upstream pready_o 3 cycles after the upstream SETUP cycle; a decode miss SHALL give it 1 cycle after.
REQ-020 pready_o SHALL be 0 outside RESP and ERR; prdata_o SHALL be 0 outside RESP.
REQ-021 Downstream address, data and write outputs SHALL stay stable from SETUP through the end of ACCESS.
REQ-022 If psel_i drops mid-transfer, the downstream transfer SHALL still complete, and the RESP pulse SHALL still be issued and then ignored.
REQ-023 err_cnt_o SHALL saturate at 255 and not wrap.
REQ-024 A new upstream SETUP SHALL be accepted only in IDLE; back-to-back transfers SHALL therefore have at least one IDLE cycle between them.

Reset
REQ-025 With rst_i=1 at a clock edge, the FSM SHALL go to IDLE and all outputs, err_cnt_o and the timeout counter SHALL clear to 0, including mid-transfer.

Configuration
REQ-026 With PERIPH_APB_TIMEOUT_EN defined, a 16-bit counter SHALL count ACCESS cycles; on reaching TIMEOUT_CYCLES without m_pready_i, the block SHALL deassert m_psel_o and m_penable_o and go to ERR.
REQ-027 Without PERIPH_APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter SHALL be instantiated.

Structure
REQ-028 Package periph_apb_pkg SHALL hold the FSM state enum, the ERR data constant (0) and the counter width constant.
REQ-029 Combinational priority decoder sub-module periph_apb_addr_dec SHALL take paddr and the windows and return hit and index.

Verification
REQ-030 Read 0x1A10_0004, target 1 window 0x1A10_0000..0x1A10_0FFF, zero wait, prdata 0xCAFE_F00D -> m_psel_o=0x002; pready_o at cycle 3 with prdata_o=0xCAFE_F00D, pslverr_o=0.
REQ-031 Write to an unmapped 0x0000_0010 -> no m_psel_o; pready_o=1 and pslverr_o=1 at cycle 1; err_cnt_o=1.
REQ-032 Overlapping windows for targets 2 and 5, address inside both -> only m_psel_o[2] asserted.
REQ-033 With the macro and TIMEOUT_CYCLES=4, target never ready -> after 4 ACCESS cycles m_psel_o=0, pslverr_o=1, prdata_o=0.
REQ-034 rst_i=1 during ACCESS -> next cycle all m_psel_o=0, pready_o=0, err_cnt_o=0; a following read completes normally.
REQ-035 260 decode misses -> err_cnt_o=255.
